// File: rtl/outarb_if.sv
// Signal bundle between the three input channel blocks and one output-port arbiter.
// The slave modport is the arbiter side; the master modport is the channel/link side.

`ifndef OUTARB_DEFS
`define OUTARB_DEFS
`define PORTW         1
`define DATAW         31
`define VCHW          1
`define TYPE_MSB      31
`define TYPE_LSB      30
`define TYPE_HEAD     2'b00
`define TYPE_BODY     2'b01
`define TYPE_TAIL     2'b10
`define TYPE_HEADTAIL 2'b11
`endif

interface outarb_if;
    logic             req_0;
    logic             req_1;
    logic             req_2;
    logic [`PORTW:0]  port_0;
    logic [`PORTW:0]  port_1;
    logic [`PORTW:0]  port_2;
    logic [`DATAW:0]  idata_0;
    logic [`DATAW:0]  idata_1;
    logic [`DATAW:0]  idata_2;
    logic             ivalid_0;
    logic             ivalid_1;
    logic             ivalid_2;
    logic [`VCHW:0]   ivch_0;
    logic [`VCHW:0]   ivch_1;
    logic [`VCHW:0]   ivch_2;
    logic             grt_0;
    logic             grt_1;
    logic             grt_2;
    logic [`DATAW:0]  odata;
    logic             ovalid;
    logic [`VCHW:0]   ovch;
    logic             busy;

    modport slave (
        input  req_0, req_1, req_2,
        input  port_0, port_1, port_2,
        input  idata_0, idata_1, idata_2,
        input  ivalid_0, ivalid_1, ivalid_2,
        input  ivch_0, ivch_1, ivch_2,
        output grt_0, grt_1, grt_2,
        output odata, ovalid, ovch, busy
    );

    modport master (
        output req_0, req_1, req_2,
        output port_0, port_1, port_2,
        output idata_0, idata_1, idata_2,
        output ivalid_0, ivalid_1, ivalid_2,
        output ivch_0, ivch_1, ivch_2,
        input  grt_0, grt_1, grt_2,
        input  odata, ovalid, ovch, busy
    );
endinterface

// File: rtl/outarb.sv
// Output-port switch arbiter and crossbar stage: round-robin packet grant over three inputs,
// one register stage on the output link. Optional stall watchdog under OUTARB_TIMEOUT_EN.

`ifndef OUTARB_DEFS
`define OUTARB_DEFS
`define PORTW         1
`define DATAW         31
`define VCHW          1
`define TYPE_MSB      31
`define TYPE_LSB      30
`define TYPE_HEAD     2'b00
`define TYPE_BODY     2'b01
`define TYPE_TAIL     2'b10
`define TYPE_HEADTAIL 2'b11
`endif

module outarb #(
    parameter int unsigned PORTID = 0
`ifdef OUTARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 15
`endif
) (
    input  logic     clk,
    input  logic     rst_,
    outarb_if.slave  bus
);

    localparam logic [`PORTW:0] PORT_SEL = PORTID[`PORTW:0];

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [1:0]        owner_r;
    logic [1:0]        owner_nxt_s;
    logic [1:0]        rr_r;
    logic [1:0]        rr_nxt_s;

    logic [2:0]        r_s;
    logic [2:0]        win_s;
    logic              own_req_s;
    logic              own_valid_s;
    logic [`DATAW:0]   own_data_s;
    logic [`VCHW:0]    own_vch_s;
    logic              own_tail_s;
    logic              release_s;
    logic              timeout_s;

    logic [2:0]        grt_r;
    logic [2:0]        grt_nxt_s;
    logic [`DATAW:0]   odata_r;
    logic [`DATAW:0]   odata_nxt_s;
    logic              ovalid_r;
    logic              ovalid_nxt_s;
    logic [`VCHW:0]    ovch_r;
    logic [`VCHW:0]    ovch_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] res;
        case (idx)
            2'd0:    res = 3'b001;
            2'd1:    res = 3'b010;
            2'd2:    res = 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] idx);
        logic [1:0] res;
        case (idx)
            2'd0:    res = 2'd1;
            2'd1:    res = 2'd2;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // Returns {found, index} of the first requester scanning from ptr with wrap-around.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        res = 3'b000;
        case (ptr)
            2'd1: begin
                if (r[1])      res = {1'b1, 2'd1};
                else if (r[2]) res = {1'b1, 2'd2};
                else if (r[0]) res = {1'b1, 2'd0};
                else           res = 3'b000;
            end
            2'd2: begin
                if (r[2])      res = {1'b1, 2'd2};
                else if (r[0]) res = {1'b1, 2'd0};
                else if (r[1]) res = {1'b1, 2'd1};
                else           res = 3'b000;
            end
            default: begin
                if (r[0])      res = {1'b1, 2'd0};
                else if (r[1]) res = {1'b1, 2'd1};
                else if (r[2]) res = {1'b1, 2'd2};
                else           res = 3'b000;
            end
        endcase
        return res;
    endfunction

    // Effective requests: only those aimed at this output port count.
    always_comb begin
        r_s[0] = bus.req_0 && (bus.port_0 == PORT_SEL);
        r_s[1] = bus.req_1 && (bus.port_1 == PORT_SEL);
        r_s[2] = bus.req_2 && (bus.port_2 == PORT_SEL);
    end

    // Crossbar select: the current owner's request and flit.
    always_comb begin
        own_req_s   = 1'b0;
        own_valid_s = 1'b0;
        own_data_s  = {(`DATAW+1){1'b0}};
        own_vch_s   = {(`VCHW+1){1'b0}};
        case (owner_r)
            2'd0: begin
                own_req_s   = r_s[0];
                own_valid_s = bus.ivalid_0;
                own_data_s  = bus.idata_0;
                own_vch_s   = bus.ivch_0;
            end
            2'd1: begin
                own_req_s   = r_s[1];
                own_valid_s = bus.ivalid_1;
                own_data_s  = bus.idata_1;
                own_vch_s   = bus.ivch_1;
            end
            2'd2: begin
                own_req_s   = r_s[2];
                own_valid_s = bus.ivalid_2;
                own_data_s  = bus.idata_2;
                own_vch_s   = bus.ivch_2;
            end
            default: begin
                own_req_s   = 1'b0;
                own_valid_s = 1'b0;
                own_data_s  = {(`DATAW+1){1'b0}};
                own_vch_s   = {(`VCHW+1){1'b0}};
            end
        endcase
    end

    assign win_s      = rr_pick(r_s, rr_r);
    assign own_tail_s = own_valid_s &&
                        ((own_data_s[`TYPE_MSB:`TYPE_LSB] == `TYPE_TAIL) ||
                         (own_data_s[`TYPE_MSB:`TYPE_LSB] == `TYPE_HEADTAIL));
    // A dropped request ends the packet just like a tail flit does.
    assign release_s  = own_tail_s || !own_req_s || timeout_s;

`ifdef OUTARB_TIMEOUT_EN
    localparam logic [3:0] TMO_LIMIT = TIMEOUT[3:0];

    logic [3:0] idle_cnt_r;
    logic [3:0] idle_cnt_nxt_s;

    // Stall counter: counts owner cycles without a flit, reset by any flit or by leaving BUSY.
    always_comb begin
        idle_cnt_nxt_s = idle_cnt_r;
        if ((state_r != ST_BUSY) || release_s || own_valid_s) begin
            idle_cnt_nxt_s = 4'd0;
        end else begin
            idle_cnt_nxt_s = idle_cnt_r + 4'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            idle_cnt_r <= 4'd0;
        end else begin
            idle_cnt_r <= idle_cnt_nxt_s;
        end
    end

    assign timeout_s = (state_r == ST_BUSY) && !own_valid_s && (idle_cnt_r == TMO_LIMIT);
`else
    assign timeout_s = 1'b0;
`endif

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_r <= ST_IDLE;
            owner_r <= 2'd0;
            rr_r    <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            rr_r    <= rr_nxt_s;
        end
    end

    // Next-state logic: grant from IDLE, release from BUSY and advance the pointer past the owner.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        rr_nxt_s    = rr_r;
        case (state_r)
            ST_IDLE: begin
                if (win_s[2]) begin
                    state_nxt_s = ST_BUSY;
                    owner_nxt_s = win_s[1:0];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (release_s) begin
                    state_nxt_s = ST_IDLE;
                    rr_nxt_s    = inc3(owner_r);
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next grant vector, busy flag and the owner's flit for the link register.
    always_comb begin
        grt_nxt_s    = 3'b000;
        odata_nxt_s  = {(`DATAW+1){1'b0}};
        ovalid_nxt_s = 1'b0;
        ovch_nxt_s   = {(`VCHW+1){1'b0}};
        busy_nxt_s   = (state_nxt_s == ST_BUSY);
        if (state_nxt_s == ST_BUSY) begin
            grt_nxt_s = onehot3(owner_nxt_s);
        end else begin
            grt_nxt_s = 3'b000;
        end
        if (state_r == ST_BUSY) begin
            ovch_nxt_s = own_vch_s;
            if (own_valid_s) begin
                odata_nxt_s  = own_data_s;
                ovalid_nxt_s = 1'b1;
            end else begin
                odata_nxt_s  = {(`DATAW+1){1'b0}};
                ovalid_nxt_s = 1'b0;
            end
        end else begin
            ovch_nxt_s   = {(`VCHW+1){1'b0}};
            odata_nxt_s  = {(`DATAW+1){1'b0}};
            ovalid_nxt_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            grt_r    <= 3'b000;
            odata_r  <= {(`DATAW+1){1'b0}};
            ovalid_r <= 1'b0;
            ovch_r   <= {(`VCHW+1){1'b0}};
            busy_r   <= 1'b0;
        end else begin
            grt_r    <= grt_nxt_s;
            odata_r  <= odata_nxt_s;
            ovalid_r <= ovalid_nxt_s;
            ovch_r   <= ovch_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign bus.grt_0  = grt_r[0];
    assign bus.grt_1  = grt_r[1];
    assign bus.grt_2  = grt_r[2];
    assign bus.odata  = odata_r;
    assign bus.ovalid = ovalid_r;
    assign bus.ovch   = ovch_r;
    assign bus.busy   = busy_r;

endmodule

// File: tb/tb_outarb.sv
// Scoreboard bench for outarb: channel tasks push expected flits, a monitor pops them
// whenever ovalid is seen and compares data/VC; grant order and timing are checked inline.

`ifndef OUTARB_DEFS
`define OUTARB_DEFS
`define PORTW         1
`define DATAW         31
`define VCHW          1
`define TYPE_MSB      31
`define TYPE_LSB      30
`define TYPE_HEAD     2'b00
`define TYPE_BODY     2'b01
`define TYPE_TAIL     2'b10
`define TYPE_HEADTAIL 2'b11
`endif

module tb_outarb;

    localparam logic [`PORTW:0] PORT_SEL   = 2'd0;
    localparam logic [`PORTW:0] PORT_OTHER = 2'd1;

    logic clk;
    logic rst_;
    int   checks;
    int   errors;
    int   cyc;

    logic            req_a    [3];
    logic [`PORTW:0] port_a   [3];
    logic [`DATAW:0] idata_a  [3];
    logic            ivalid_a [3];
    logic [`VCHW:0]  ivch_a   [3];
    logic [2:0]      grt;

    logic [`DATAW:0] exp_data [$];
    logic [`VCHW:0]  exp_vch  [$];
    int              grant_ch [$];
    int              grant_cyc[$];
    int              req_cyc  [3];
    int              tail_cyc [3];

    outarb_if bus_if ();

    outarb #(.PORTID(0)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus_if)
    );

    assign bus_if.req_0    = req_a[0];
    assign bus_if.req_1    = req_a[1];
    assign bus_if.req_2    = req_a[2];
    assign bus_if.port_0   = port_a[0];
    assign bus_if.port_1   = port_a[1];
    assign bus_if.port_2   = port_a[2];
    assign bus_if.idata_0  = idata_a[0];
    assign bus_if.idata_1  = idata_a[1];
    assign bus_if.idata_2  = idata_a[2];
    assign bus_if.ivalid_0 = ivalid_a[0];
    assign bus_if.ivalid_1 = ivalid_a[1];
    assign bus_if.ivalid_2 = ivalid_a[2];
    assign bus_if.ivch_0   = ivch_a[0];
    assign bus_if.ivch_1   = ivch_a[1];
    assign bus_if.ivch_2   = ivch_a[2];
    assign grt = {bus_if.grt_2, bus_if.grt_1, bus_if.grt_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [`DATAW:0] make_flit(input logic [1:0] ft, input int tag, input int idx);
        logic [29:0] pl;
        pl = 30'((tag << 8) | idx);
        return {ft, pl};
    endfunction

    // One input channel: request, wait for grant (bounded), stream the packet, release.
    task automatic chan_pkt(input int ch, input int nflits, input int tag);
        int         waited;
        logic [1:0] ft;
        waited      = 0;
        req_a[ch]   = 1'b1;
        port_a[ch]  = PORT_SEL;
        ivch_a[ch]  = 2'(ch + 1);
        req_cyc[ch] = cyc;
        tick();
        while (grt[ch] !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        if (grt[ch] !== 1'b1) begin
            check("grant_wait", 32'(grt[ch]), 32'd1);
            req_a[ch] = 1'b0;
            return;
        end
        grant_ch.push_back(ch);
        grant_cyc.push_back(cyc);
        for (int i = 0; i < nflits; i++) begin
            check("grt_hold", 32'(grt[ch]), 32'd1);
            check("busy_hold", 32'(bus_if.busy), 32'd1);
            if (nflits == 1)          ft = `TYPE_HEADTAIL;
            else if (i == 0)          ft = `TYPE_HEAD;
            else if (i == nflits - 1) ft = `TYPE_TAIL;
            else                      ft = `TYPE_BODY;
            idata_a[ch]  = make_flit(ft, tag, i);
            ivalid_a[ch] = 1'b1;
            exp_data.push_back(idata_a[ch]);
            exp_vch.push_back(ivch_a[ch]);
            tail_cyc[ch] = cyc;
            tick();
        end
        ivalid_a[ch] = 1'b0;
        req_a[ch]    = 1'b0;
        check("grt_drop", 32'(grt[ch]), 32'd0);
        check("busy_drop", 32'(bus_if.busy), 32'd0);
    endtask

    // Output monitor: every valid flit must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [`DATAW:0] d;
        logic [`VCHW:0]  v;
        if (!rst_) begin
            if (!$onehot0(grt)) begin
                checks++;
                errors++;
                $display("FAIL grt_onehot: got %b, required at most one bit", grt);
            end
            if (bus_if.ovalid === 1'b1) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit: got 0x%0h, expected no flit", bus_if.odata);
                end else begin
                    d = exp_data.pop_front();
                    v = exp_vch.pop_front();
                    check("odata", bus_if.odata, d);
                    check("ovch", 32'(bus_if.ovch), 32'(v));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int waited;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_a[i]    = 1'b0;
            port_a[i]   = PORT_SEL;
            idata_a[i]  = {(`DATAW+1){1'b0}};
            ivalid_a[i] = 1'b0;
            ivch_a[i]   = 2'd0;
        end
        tick();
        tick();
        check("rst_grt", 32'(grt), 32'd0);
        check("rst_odata", bus_if.odata, 32'd0);
        check("rst_ovalid", 32'(bus_if.ovalid), 32'd0);
        check("rst_ovch", 32'(bus_if.ovch), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        rst_ = 1'b0;
        tick();

        // Round robin twice: pointer starts at 0 and wraps back to 0.
        for (int rep = 0; rep < 2; rep++) begin
            grant_ch.delete();
            grant_cyc.delete();
            fork
                chan_pkt(0, 1, 16 + rep * 4);
                chan_pkt(1, 1, 17 + rep * 4);
                chan_pkt(2, 1, 18 + rep * 4);
            join
            check("rr_count", 32'(grant_ch.size()), 32'd3);
            if (grant_ch.size() == 3) begin
                check("rr_first", 32'(grant_ch[0]), 32'd0);
                check("rr_second", 32'(grant_ch[1]), 32'd1);
                check("rr_third", 32'(grant_ch[2]), 32'd2);
                check("rr_lat", 32'(grant_cyc[0] - req_cyc[0]), 32'd1);
                check("rr_gap01", 32'(grant_cyc[1] - grant_cyc[0]), 32'd2);
                check("rr_gap12", 32'(grant_cyc[2] - grant_cyc[1]), 32'd2);
            end
            tick();
        end

        // Single 4-flit packet from input 1.
        grant_ch.delete();
        grant_cyc.delete();
        chan_pkt(1, 4, 40);
        check("single_grant_lat", 32'(grant_cyc[0] - req_cyc[1]), 32'd1);
        check("single_tail", 32'(tail_cyc[1] - grant_cyc[0]), 32'd3);
        tick();

        // Request aimed at another port must be ignored.
        req_a[2]  = 1'b1;
        port_a[2] = PORT_OTHER;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("filt_grt", 32'(grt), 32'd0);
            check("filt_ovalid", 32'(bus_if.ovalid), 32'd0);
        end
        req_a[2]  = 1'b0;
        port_a[2] = PORT_SEL;
        tick();

        // Contention: input 1 waits for input 0's tail, granted two cycles after it.
        grant_ch.delete();
        grant_cyc.delete();
        fork
            chan_pkt(0, 4, 50);
            begin
                tick();
                tick();
                chan_pkt(1, 2, 51);
            end
        join
        check("cont_count", 32'(grant_ch.size()), 32'd2);
        if (grant_ch.size() == 2) begin
            check("cont_order", 32'(grant_ch[1]), 32'd1);
            check("cont_gap", 32'(grant_cyc[1] - tail_cyc[0]), 32'd2);
        end
        tick();

        // Reset in the middle of a packet owned by input 2 (pointer is 2 at this point).
        req_a[2]  = 1'b1;
        port_a[2] = PORT_SEL;
        ivch_a[2] = 2'd3;
        tick();
        check("rstmid_grant", 32'(grt), 32'd4);
        idata_a[2]  = make_flit(`TYPE_HEAD, 60, 0);
        ivalid_a[2] = 1'b1;
        exp_data.push_back(idata_a[2]);
        exp_vch.push_back(ivch_a[2]);
        tick();
        idata_a[2] = make_flit(`TYPE_BODY, 60, 1);
        @(negedge clk);
        #1;
        rst_ = 1'b1;
        #1;
        check("rstmid_grt", 32'(grt), 32'd0);
        check("rstmid_ovalid", 32'(bus_if.ovalid), 32'd0);
        check("rstmid_busy", 32'(bus_if.busy), 32'd0);
        req_a[2]    = 1'b0;
        ivalid_a[2] = 1'b0;
        tick();
        tick();
        rst_ = 1'b0;
        grant_ch.delete();
        grant_cyc.delete();
        fork
            chan_pkt(0, 1, 70);
            chan_pkt(1, 1, 71);
            chan_pkt(2, 1, 72);
        join
        if (grant_ch.size() == 3) begin
            check("post_rst_first", 32'(grant_ch[0]), 32'd0);
        end else begin
            check("post_rst_count", 32'(grant_ch.size()), 32'd3);
        end
        tick();

`ifdef OUTARB_TIMEOUT_EN
        // Owner stalls after HEAD; watchdog releases and pending input 2 follows.
        grant_ch.delete();
        grant_cyc.delete();
        req_a[0]  = 1'b1;
        port_a[0] = PORT_SEL;
        ivch_a[0] = 2'd1;
        req_a[2]  = 1'b1;
        port_a[2] = PORT_SEL;
        tick();
        check("tmo_grant", 32'(grt), 32'd1);
        idata_a[0]  = make_flit(`TYPE_HEAD, 80, 0);
        ivalid_a[0] = 1'b1;
        exp_data.push_back(idata_a[0]);
        exp_vch.push_back(ivch_a[0]);
        tick();
        ivalid_a[0] = 1'b0;
        waited = 0;
        while (grt[0] === 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check("tmo_release", 32'(grt[0]), 32'd0);
        check("tmo_not_early", 32'(waited >= 15), 32'd1);
        req_a[0] = 1'b0;
        chan_pkt(2, 1, 81);
        check("tmo_next", 32'(grant_ch.size() == 1 && grant_ch[0] == 2), 32'd1);
        tick();
`endif

        tick();
        tick();
        check("scoreboard_drain", 32'(exp_data.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
